// File: rtl/ddr3_traffic_gen_pkg.sv
// Shared definitions for the DDR3 AXI4-Lite traffic generator.
//   state_e       - top-level FSM states
//   STATUS_*      - bit positions inside the o_status result word
//   LFSR_TAPS     - Galois feedback mask for the 32-bit data generator
//   lfsr_next()   - one Galois step (shift right, xor taps when bit 0 falls out)
package ddr3_traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_e;

  localparam int unsigned STATUS_MISMATCH = 31;
  localparam int unsigned STATUS_TIMEOUT  = 30;
  localparam int unsigned STATUS_RESP_ERR = 29;
  localparam int unsigned STATUS_PHASE    = 28;
  localparam int unsigned STATUS_IDX_MSB  = 27;
  localparam int unsigned STATUS_IDX_LSB  = 16;
  localparam int unsigned STATUS_CNT_MSB  = 15;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/traffic_gen_lfsr32.sv
// 32-bit Galois LFSR used as the write-data / expected-read-data generator.
//   clk   - clock
//   load  - load seed (wins over step); also used as the reset path
//   seed  - value loaded on load
//   step  - advance one position
//   q     - current LFSR value
module traffic_gen_lfsr32
  import ddr3_traffic_gen_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/ddr3_axi_lite_traffic_gen.sv
// Self-checking AXI4-Lite master: writes NUM_WORDS LFSR words to consecutive addresses,
// reads them all back and compares, then reports on o_done / o_status.
//   i_controller_clk, i_rst_n    - clock, synchronous active-low reset
//   m_axi_lite_aw*/w*/b*         - write address / data / response channels
//   m_axi_lite_ar*/r*            - read address / data channels
//   o_done                       - sticky test-finished flag
//   o_status                     - {mismatch, timeout, resp_err, phase, first_idx[11:0], count[15:0]}
// o_status reads all-zero on a clean pass; the phase bit is only recorded when an error flag
// is set, so a nonzero word always means something went wrong.
module ddr3_axi_lite_traffic_gen
  import ddr3_traffic_gen_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
  parameter int unsigned           ADDR_STRIDE    = 4,
  parameter int unsigned           NUM_WORDS      = 256,
  parameter logic [31:0]           SEED           = 32'hACE1_1234,
  parameter int unsigned           TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_controller_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic [2:0]            m_axi_lite_awprot,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [31:0]           m_axi_lite_wdata,
  output logic [3:0]            m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [1:0]            m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [31:0]           m_axi_lite_rdata,
  input  logic [1:0]            m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready,
  output logic                  o_done,
  output logic [31:0]           o_status
);

  state_e      state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] status_q, status_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic        done_q, done_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_val;
  logic        aw_hs, w_hs, last_idx, wait_state, rd_phase;
  logic [ADDR_WIDTH-1:0] addr;

  traffic_gen_lfsr32 u_lfsr (
    .clk  (i_controller_clk),
    .load (lfsr_load | ~i_rst_n),
    .seed (SEED),
    .step (lfsr_step),
    .q    (lfsr_val)
  );

  // Address wraps naturally at 2^ADDR_WIDTH; idx_q is constant while a request is pending.
  assign addr = START_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);

  assign aw_hs      = awvalid_q & m_axi_lite_awready;
  assign w_hs       = wvalid_q & m_axi_lite_wready;
  assign last_idx   = (idx_q == 12'(NUM_WORDS - 1));
  assign wait_state = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_DATA);
  assign rd_phase   = (state_q == RD_REQ) || (state_q == RD_DATA);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    status_d  = status_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    done_d    = done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    tmo_d     = tmo_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE: begin
        state_d   = WR_REQ;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Either channel may have finished earlier or both in this very cycle.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_lite_bvalid) begin
          bready_d  = 1'b0;
          lfsr_step = 1'b1;
          if (m_axi_lite_bresp != 2'b00) status_d[STATUS_RESP_ERR] = 1'b1;
          if (last_idx) begin
            // Rewind the generator so the read pass reproduces the written sequence.
            lfsr_load = 1'b1;
            idx_d     = '0;
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end else begin
            idx_d     = idx_q + 12'd1;
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
      end
      RD_REQ: begin
        if (m_axi_lite_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_lite_rvalid) begin
          rready_d  = 1'b0;
          lfsr_step = 1'b1;
          if (m_axi_lite_rresp != 2'b00) status_d[STATUS_RESP_ERR] = 1'b1;
          if (m_axi_lite_rdata != lfsr_val) begin
            if (!status_q[STATUS_MISMATCH]) begin
              status_d[STATUS_IDX_MSB:STATUS_IDX_LSB] = idx_q;
            end
            status_d[STATUS_MISMATCH] = 1'b1;
            if (status_q[STATUS_CNT_MSB:0] != 16'hFFFF) begin
              status_d[STATUS_CNT_MSB:0] = status_q[STATUS_CNT_MSB:0] + 16'd1;
            end
          end
          if (last_idx) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 12'd1;
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cycle counter restarts on every state entry; only wait states accumulate.
    if (state_d != state_q || !wait_state) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    if (wait_state && (state_d == state_q) && (tmo_q == 32'(TIMEOUT_CYCLES - 1))) begin
      state_d   = DONE;
      done_d    = 1'b1;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      bready_d  = 1'b0;
      rready_d  = 1'b0;
      tmo_d     = '0;
      status_d[STATUS_TIMEOUT] = 1'b1;
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      status_d[STATUS_PHASE] = rd_phase &&
          (status_d[STATUS_MISMATCH] || status_d[STATUS_TIMEOUT] || status_d[STATUS_RESP_ERR]);
    end
  end

  always_ff @(posedge i_controller_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      status_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      status_q  <= status_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign m_axi_lite_awaddr  = addr;
  assign m_axi_lite_awprot  = 3'b000;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = lfsr_val;
  assign m_axi_lite_wstrb   = 4'hF;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_araddr  = addr;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_rready  = rready_q;
  assign o_done             = done_q;
  assign o_status           = status_q;

endmodule
